// File: rtl/bp_pkg.sv
// Types and constants shared by the branch predictor and its resolver.
// Pure declarations, no logic.
package bp_pkg;

  // 2-bit direction counter state used by branch_predictor tables.
  typedef enum logic [1:0] {
    SAT_STRONG_NT = 2'b00,
    SAT_WEAK_NT   = 2'b01,
    SAT_WEAK_T    = 2'b10,
    SAT_STRONG_T  = 2'b11
  } saturation_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
  } bp_entry_t;

  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/bp_fifo.sv
// In-order store of in-flight predictions; head entry readable combinationally.
// Zero-latency push/pop. Push is refused when full or flushing; flush empties at the edge.
module bp_fifo
  import bp_pkg::*;
#(
  parameter int LOG_DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  bp_entry_t            push_dat,
  input  logic                 pop,
  input  logic                 flush,
  output bp_entry_t            head_dat,
  output logic                 full,
  output logic                 empty,
  output logic [LOG_DEPTH:0]   count
);

  localparam int DEPTH = 1 << LOG_DEPTH;

  bp_entry_t              mem_q [DEPTH];
  bp_entry_t              mem_d [DEPTH];
  logic [LOG_DEPTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LOG_DEPTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LOG_DEPTH:0]     count_q, count_d;
  logic                   push_acc;
  logic                   pop_acc;

  assign full     = (count_q == (LOG_DEPTH+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];

  assign push_acc = push && !full && !flush;
  assign pop_acc  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_acc) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (flush) begin
      // Everything between head and tail is discarded in one step.
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (pop_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (LOG_DEPTH+1)'(push_acc) - (LOG_DEPTH+1)'(pop_acc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Retires fetch predictions against execute outcomes; trains predictor, flushes on mispredict.
// Update/redirect outputs one cycle after resolve; pred_ready = !full. BRANCH_RESOLVER_STATS_EN adds counters.
module branch_resolver
  import bp_pkg::*;
#(
  parameter int LOG_DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pred_valid,
  output logic                 pred_ready,
  input  logic [31:0]          pred_pc,
  input  logic                 pred_taken,
  input  logic                 res_valid,
  input  logic                 res_taken,
  input  logic [31:0]          res_target,
  output logic                 update,
  output logic [31:0]          update_pc,
  output logic                 was_taken,
  output logic                 mispredict,
  output logic [31:0]          redirect_pc,
  output logic                 underflow_err,
  output logic [LOG_DEPTH:0]   occupancy
`ifdef BRANCH_RESOLVER_STATS_EN
  ,
  output logic [31:0]          stat_resolved,
  output logic [31:0]          stat_mispredicts
`endif
);

  bp_entry_t   push_dat;
  bp_entry_t   head_dat;
  logic        full;
  logic        empty;
  logic        res_acc;
  logic        miss;

  logic        update_q, update_d;
  logic [31:0] update_pc_q, update_pc_d;
  logic        was_taken_q, was_taken_d;
  logic        mispredict_q, mispredict_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        underflow_q, underflow_d;

  assign push_dat = '{pc: pred_pc, taken: pred_taken};
  assign res_acc  = res_valid && !empty;
  assign miss     = res_acc && (head_dat.taken != res_taken);

  bp_fifo #(.LOG_DEPTH(LOG_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push     (pred_valid),
    .push_dat (push_dat),
    .pop      (res_acc),
    .flush    (miss),
    .head_dat (head_dat),
    .full     (full),
    .empty    (empty),
    .count    (occupancy)
  );

  assign pred_ready = !full;

  always_comb begin
    update_d      = 1'b0;
    mispredict_d  = 1'b0;
    update_pc_d   = update_pc_q;
    was_taken_d   = was_taken_q;
    redirect_pc_d = redirect_pc_q;
    underflow_d   = underflow_q || (res_valid && empty);
    if (res_acc) begin
      update_d      = 1'b1;
      update_pc_d   = head_dat.pc;
      was_taken_d   = res_taken;
      mispredict_d  = miss;
      // Fall-through wraps modulo 2**32 by construction of the 32-bit add.
      redirect_pc_d = res_taken ? res_target : head_dat.pc + 32'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      update_q      <= 1'b0;
      update_pc_q   <= '0;
      was_taken_q   <= 1'b0;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
      underflow_q   <= 1'b0;
    end else begin
      update_q      <= update_d;
      update_pc_q   <= update_pc_d;
      was_taken_q   <= was_taken_d;
      mispredict_q  <= mispredict_d;
      redirect_pc_q <= redirect_pc_d;
      underflow_q   <= underflow_d;
    end
  end

  assign update        = update_q;
  assign update_pc     = update_pc_q;
  assign was_taken     = was_taken_q;
  assign mispredict    = mispredict_q;
  assign redirect_pc   = redirect_pc_q;
  assign underflow_err = underflow_q;

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] stat_resolved_q, stat_resolved_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  always_comb begin
    stat_resolved_d    = stat_resolved_q + 32'(res_acc);
    stat_mispredicts_d = stat_mispredicts_q + 32'(miss);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_resolved_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_resolved_q    <= stat_resolved_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_resolved    = stat_resolved_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: reset, retire, flush, full/wrap, redirect wrap, async reset.
module tb_branch_resolver;

  localparam int LOG_DEPTH = 3;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               pred_valid = 1'b0;
  logic               pred_ready;
  logic [31:0]        pred_pc = '0;
  logic               pred_taken = 1'b0;
  logic               res_valid = 1'b0;
  logic               res_taken = 1'b0;
  logic [31:0]        res_target = '0;
  logic               update;
  logic [31:0]        update_pc;
  logic               was_taken;
  logic               mispredict;
  logic [31:0]        redirect_pc;
  logic               underflow_err;
  logic [LOG_DEPTH:0] occupancy;
`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0]        stat_resolved;
  logic [31:0]        stat_mispredicts;
`endif

  int n_checks = 0;
  int n_errors = 0;

  branch_resolver #(.LOG_DEPTH(LOG_DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .pred_valid    (pred_valid),
    .pred_ready    (pred_ready),
    .pred_pc       (pred_pc),
    .pred_taken    (pred_taken),
    .res_valid     (res_valid),
    .res_taken     (res_taken),
    .res_target    (res_target),
    .update        (update),
    .update_pc     (update_pc),
    .was_taken     (was_taken),
    .mispredict    (mispredict),
    .redirect_pc   (redirect_pc),
    .underflow_err (underflow_err),
    .occupancy     (occupancy)
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    .stat_resolved    (stat_resolved),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    pred_valid = 1'b0;
    res_valid  = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic push(input logic [31:0] pc, input logic tk);
    pred_valid = 1'b1;
    pred_pc    = pc;
    pred_taken = tk;
    tick();
    pred_valid = 1'b0;
  endtask

  task automatic resolve(input logic tk, input logic [31:0] tgt);
    res_valid  = 1'b1;
    res_taken  = tk;
    res_target = tgt;
    tick();
    res_valid = 1'b0;
  endtask

  logic [31:0] exp_pc [8];

  initial begin
    // 1: reset state
    do_reset();
    check("rst_ready", 32'(pred_ready), 32'd1);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_update", 32'(update), 32'd0);
    check("rst_mispredict", 32'(mispredict), 32'd0);
    check("rst_underflow", 32'(underflow_err), 32'd0);

    // 2: simple correct prediction
    push(32'h100, 1'b1);
    check("t2_occ1", 32'(occupancy), 32'd1);
    resolve(1'b1, 32'h500);
    check("t2_update", 32'(update), 32'd1);
    check("t2_update_pc", update_pc, 32'h100);
    check("t2_was_taken", 32'(was_taken), 32'd1);
    check("t2_mispredict", 32'(mispredict), 32'd0);
    check("t2_occ0", 32'(occupancy), 32'd0);
    tick();
    check("t2_update_pulse", 32'(update), 32'd0);
    check("t2_pc_hold", update_pc, 32'h100);

    // 3: mispredict flush with concurrent push dropped, then underflow
    push(32'h100, 1'b1);
    push(32'h104, 1'b0);
    push(32'h108, 1'b1);
    check("t3_occ3", 32'(occupancy), 32'd3);
    pred_valid = 1'b1;
    pred_pc    = 32'h10C;
    pred_taken = 1'b0;
    resolve(1'b0, 32'h900);
    pred_valid = 1'b0;
    check("t3_mispredict", 32'(mispredict), 32'd1);
    check("t3_redirect", redirect_pc, 32'h104);
    check("t3_was_taken", 32'(was_taken), 32'd0);
    check("t3_occ_flushed", 32'(occupancy), 32'd0);
    resolve(1'b1, 32'h0);
    check("t3_underflow", 32'(underflow_err), 32'd1);
    check("t3_no_update", 32'(update), 32'd0);
    check("t3_occ_still0", 32'(occupancy), 32'd0);
    tick();
    check("t3_underflow_sticky", 32'(underflow_err), 32'd1);
    check("t3_mispredict_pulse", 32'(mispredict), 32'd0);

    // 4: fill, overflow attempt, push+pop while full, drain order
    do_reset();
    check("t4_underflow_clr", 32'(underflow_err), 32'd0);
    for (int i = 0; i < 8; i++) push(32'h200 + 32'(4 * i), 1'b0);
    check("t4_full_ready", 32'(pred_ready), 32'd0);
    check("t4_full_occ", 32'(occupancy), 32'd8);
    push(32'h300, 1'b0);
    check("t4_ninth_occ", 32'(occupancy), 32'd8);
    pred_valid = 1'b1;
    pred_pc    = 32'h400;
    pred_taken = 1'b0;
    resolve(1'b0, 32'h0);
    check("t4_pp_full_occ", 32'(occupancy), 32'd7);
    check("t4_pp_full_pc", update_pc, 32'h200);
    pred_valid = 1'b1;
    pred_pc    = 32'h404;
    resolve(1'b0, 32'h0);
    pred_valid = 1'b0;
    check("t4_pp_occ", 32'(occupancy), 32'd7);
    check("t4_pp_pc", update_pc, 32'h204);
    push(32'h408, 1'b0);
    check("t4_refill_occ", 32'(occupancy), 32'd8);
    for (int i = 0; i < 5; i++) exp_pc[i] = 32'h208 + 32'(4 * i);
    exp_pc[5] = 32'h21C;
    exp_pc[6] = 32'h404;
    exp_pc[7] = 32'h408;
    // 0x400 was pushed while full and must not appear; 0x300 likewise.
    for (int i = 0; i < 8; i++) begin
      resolve(1'b0, 32'h0);
      check($sformatf("t4_drain%0d", i), update_pc, exp_pc[i]);
    end
    check("t4_drained_occ", 32'(occupancy), 32'd0);
    check("t4_no_underflow", 32'(underflow_err), 32'd0);

    // 4b: pointer wrap over 20 push/pop pairs
    push(32'h1000, 1'b0);
    for (int i = 0; i < 20; i++) begin
      pred_valid = 1'b1;
      pred_pc    = 32'h1000 + 32'(4 * (i + 1));
      pred_taken = 1'((i + 1) & 1);
      resolve(1'((i) & 1), 32'hDEAD0000);
      pred_valid = 1'b0;
      check($sformatf("t4w_pc%0d", i), update_pc, 32'h1000 + 32'(4 * i));
      check($sformatf("t4w_mp%0d", i), 32'(mispredict), 32'd0);
    end
    check("t4w_occ", 32'(occupancy), 32'd1);

    // 5: redirect targets including 32-bit wrap
    do_reset();
    push(32'hFFFF_FFFC, 1'b0);
    resolve(1'b1, 32'h40);
    check("t5_mp_taken", 32'(mispredict), 32'd1);
    check("t5_redirect_tgt", redirect_pc, 32'h40);
    push(32'hFFFF_FFFC, 1'b1);
    resolve(1'b0, 32'h1234);
    check("t5_mp_nt", 32'(mispredict), 32'd1);
    check("t5_redirect_wrap", redirect_pc, 32'h0);
    check("t5_update_pc", update_pc, 32'hFFFF_FFFC);

    // 6: async reset with entries queued
    for (int i = 0; i < 5; i++) push(32'h2000 + 32'(4 * i), 1'b1);
    check("t6_occ5", 32'(occupancy), 32'd5);
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_occ", 32'(occupancy), 32'd0);
    check("t6_async_ready", 32'(pred_ready), 32'd1);
    check("t6_async_redirect", redirect_pc, 32'h0);
    tick();
    reset = 1'b1;
    tick();

`ifdef BRANCH_RESOLVER_STATS_EN
    check("t6_stat_res0", stat_resolved, 32'd0);
    check("t6_stat_mp0", stat_mispredicts, 32'd0);
    push(32'h3000, 1'b1);
    push(32'h3004, 1'b1);
    push(32'h3008, 1'b0);
    resolve(1'b1, 32'h0);
    resolve(1'b1, 32'h0);
    resolve(1'b1, 32'h0);
    check("t6_stat_res", stat_resolved, 32'd3);
    check("t6_stat_mp", stat_mispredicts, 32'd1);
    resolve(1'b1, 32'h0);
    check("t6_stat_res_underflow", stat_resolved, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1 (bench did not complete)");
    $fatal(1, "timeout");
  end

endmodule
